// File: rtl/aes_composite_modes_pkg.sv
// Shared types and GF(2^8) helpers for the composite-mode AES engine.
// The S-box is computed as the field inverse followed by the AES affine map.
package aes_comp_pkg;

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_composite_modes_if.sv
// Host-side bus of the composite-mode AES engine: key/IV/data strobes and results.
interface aes_composite_modes_if;
  logic [127:0] Kin;
  logic         Krdy;
  logic [127:0] IVin;
  logic         IVrdy;
  logic [1:0]   Mode;
  logic [127:0] Din;
  logic         Drdy;
  logic [127:0] Dout;
  logic         Dvld;
  logic         Kvld;
  logic         BSY;

  modport master (output Kin, Krdy, IVin, IVrdy, Mode, Din, Drdy,
                  input  Dout, Dvld, Kvld, BSY);
  modport slave  (input  Kin, Krdy, IVin, IVrdy, Mode, Din, Drdy,
                  output Dout, Dvld, Kvld, BSY);
endinterface

// File: rtl/aes_composite_modes_mode_unit.sv
// Mode wrapper around the block cipher: input mux, CTR output XOR and the
// chain register (CBC feedback / CTR counter block).
module aes_mode_unit
  import aes_comp_pkg::*;
#(
  parameter int         CTR_W    = 32,
  parameter logic [2:0] MODES_EN = 3'b111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         chain_upd,
  input  logic [1:0]   mode_sel,
  input  logic [127:0] din,
  input  mode_e        mode_blk,
  input  logic [127:0] din_blk,
  input  logic [127:0] cipher_res,
  output mode_e        mode_eff,
  output logic [127:0] cipher_in,
  output logic [127:0] dout_next
);

  // Counter increments stay inside the low CTR_W bits; CTR_W = 128 gives all ones.
  localparam logic [128:0] CTR_ONE  = 129'd1 << CTR_W;
  localparam logic [127:0] CTR_MASK = CTR_ONE[127:0] - 128'd1;

  logic [127:0] chain_r;

  // Resolve the requested mode; disabled or reserved modes fall back to ECB.
  always_comb begin
    case (mode_sel)
      2'd1:    mode_eff = MODES_EN[1] ? MODE_CBC : MODE_ECB;
      2'd2:    mode_eff = MODES_EN[2] ? MODE_CTR : MODE_ECB;
      default: mode_eff = MODE_ECB;
    endcase
  end

  // Cipher input selection and the CTR keystream XOR on the way out.
  always_comb begin
    case (mode_eff)
      MODE_CBC: cipher_in = din ^ chain_r;
      MODE_CTR: cipher_in = chain_r;
      default:  cipher_in = din;
    endcase
    if (mode_blk == MODE_CTR) begin
      dout_next = din_blk ^ cipher_res;
    end else begin
      dout_next = cipher_res;
    end
  end

  // Chain register: IV load from the host, feedback update at block completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= 128'h0;
    end else if (en) begin
      if (iv_load) begin
        chain_r <= iv;
      end else if (chain_upd) begin
        case (mode_blk)
          MODE_CBC: chain_r <= cipher_res;
          MODE_CTR: chain_r <= (chain_r & ~CTR_MASK) | ((chain_r + 128'd1) & CTR_MASK);
          default:  chain_r <= chain_r;
        endcase
      end
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule step: derives the next round key from the current one.
module aes_key_expand
  import aes_comp_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] temp_s, n0_s, n1_s, n2_s, n3_s;

  // RotWord, SubWord and rcon on the last word, then the running XOR chain.
  always_comb begin
    temp_s = {sbox(key_in[23:16]) ^ rcon, sbox(key_in[15:8]),
              sbox(key_in[7:0]), sbox(key_in[31:24])};
    n0_s    = key_in[127:96] ^ temp_s;
    n1_s    = key_in[95:64] ^ n0_s;
    n2_s    = key_in[63:32] ^ n1_s;
    n3_s    = key_in[31:0] ^ n2_s;
    key_out = {n0_s, n1_s, n2_s, n3_s};
  end

endmodule

// File: rtl/aes_round_core.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_core
  import aes_comp_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(4*c+rr) -: 8] = sbox(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic [127:0] ss_s;

  // Round datapath; the last round skips MixColumns.
  always_comb begin
    ss_s = sub_shift(state_in);
    if (final_round) begin
      state_out = ss_s ^ round_key;
    end else begin
      state_out = mix_columns(ss_s) ^ round_key;
    end
  end

endmodule

// File: rtl/aes_composite_modes.sv
// Iterative AES-128 encryptor (one round per cycle) with ECB/CBC/CTR modes.
// Round keys are regenerated from the stored key for every block.
module aes_composite_modes
  import aes_comp_pkg::*;
#(
  parameter int         NR       = 10,
  parameter int         CTR_W    = 32,
  parameter logic [2:0] MODES_EN = 3'b111
) (
  input logic             CLK,
  input logic             RSTn,
  input logic             EN,
  aes_composite_modes_if.slave bus
);

  localparam logic [3:0] NR_C = 4'(NR);

  state_e       fsm_r;
  mode_e        mode_r;
  mode_e        mode_eff_s;
  logic [127:0] key_r, rk_r, st_r, din_r, dout_r;
  logic [7:0]   rcon_r;
  logic [3:0]   cnt_r;
  logic         dvld_r, kvld_r, bsy_r;
  logic [127:0] next_rk_s, round_out_s, cipher_in_s, dout_next_s;
  logic         iv_load_s, chain_upd_s, final_s;

  assign iv_load_s   = (fsm_r == ST_IDLE) && !bus.Krdy && bus.IVrdy;
  assign chain_upd_s = (fsm_r == ST_DONE);
  assign final_s     = (cnt_r == NR_C);

  aes_key_expand u_kexp (.key_in(rk_r), .rcon(rcon_r), .key_out(next_rk_s));

  aes_round_core u_round (
    .state_in(st_r), .round_key(next_rk_s), .final_round(final_s), .state_out(round_out_s)
  );

  aes_mode_unit #(.CTR_W(CTR_W), .MODES_EN(MODES_EN)) u_mode (
    .clk(CLK), .rst_n(RSTn), .en(EN), .iv_load(iv_load_s), .iv(bus.IVin),
    .chain_upd(chain_upd_s), .mode_sel(bus.Mode), .din(bus.Din), .mode_blk(mode_r),
    .din_blk(din_r), .cipher_res(st_r), .mode_eff(mode_eff_s),
    .cipher_in(cipher_in_s), .dout_next(dout_next_s)
  );

  // Control FSM and datapath registers; strobes are honoured only in IDLE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fsm_r  <= ST_IDLE;
      mode_r <= MODE_ECB;
      key_r  <= 128'h0;
      rk_r   <= 128'h0;
      st_r   <= 128'h0;
      din_r  <= 128'h0;
      dout_r <= 128'h0;
      rcon_r <= RCON_INIT;
      cnt_r  <= 4'd0;
      dvld_r <= 1'b0;
      kvld_r <= 1'b0;
      bsy_r  <= 1'b0;
    end else if (EN) begin
      dvld_r <= 1'b0;
      kvld_r <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (bus.Krdy) begin
            key_r  <= bus.Kin;
            kvld_r <= 1'b1;
          end else if (bus.Drdy && !bus.IVrdy) begin
            mode_r <= mode_eff_s;
            din_r  <= bus.Din;
            st_r   <= cipher_in_s ^ key_r;
            rk_r   <= key_r;
            rcon_r <= RCON_INIT;
            cnt_r  <= 4'd1;
            bsy_r  <= 1'b1;
            fsm_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          st_r   <= round_out_s;
          rk_r   <= next_rk_s;
          rcon_r <= xtime(rcon_r);
          cnt_r  <= cnt_r + 4'd1;
          if (final_s) begin
            fsm_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          dout_r <= dout_next_s;
          dvld_r <= 1'b1;
          bsy_r  <= 1'b0;
          fsm_r  <= ST_IDLE;
        end
        default: fsm_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.Dout = dout_r;
  assign bus.Dvld = dvld_r;
  assign bus.Kvld = kvld_r;
  assign bus.BSY  = bsy_r;

endmodule

// File: tb/tb_aes_composite_modes.sv
// Directed bench for aes_composite_modes: FIPS-197 / SP800-38A vectors plus
// hand-written sequences for strobe priority, busy-time strobes, stalls and reset.
module tb_aes_composite_modes;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] E1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CBC1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CTRB = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTR1 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] CTR2 = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] WRAP = 128'h000000000000000000000000ffffffff;
  localparam logic [127:0] ZENC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic CLK = 1'b0;
  logic RSTn;
  logic EN;
  int   n_cmp = 0;
  int   n_bad = 0;

  aes_composite_modes_if bus();

  aes_composite_modes #(.NR(10), .CTR_W(32), .MODES_EN(3'b111)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         load_key;
    logic [127:0] key;
    logic         load_iv;
    logic [127:0] iv;
    logic [1:0]   mode;
    logic [127:0] din;
    logic         check;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.Kin  = k;
    bus.Krdy = 1'b1;
    @(negedge CLK);
    bus.Krdy = 1'b0;
    chk("kvld_on_load", 128'(bus.Kvld), 128'd1);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    bus.IVin  = iv;
    bus.IVrdy = 1'b1;
    @(negedge CLK);
    bus.IVrdy = 1'b0;
  endtask

  // Issues one block; stall_at > 0 drops EN for three edges starting at that cycle.
  task automatic run_block(input logic [1:0] mode, input logic [127:0] din, input int stall_at,
                           output logic [127:0] dout, output int lat);
    bus.Mode = mode;
    bus.Din  = din;
    bus.Drdy = 1'b1;
    @(negedge CLK);
    bus.Drdy = 1'b0;
    chk("bsy_after_start", 128'(bus.BSY), 128'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      EN = (stall_at > 0 && k >= stall_at && k < stall_at + 3) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (bus.Dvld) begin
        lat = k;
        break;
      end
    end
    EN = 1'b1;
    chk("bsy_at_dvld", 128'(bus.BSY), 128'd0);
    dout = bus.Dout;
  endtask

  initial begin
    logic [127:0] dout;
    int           lat;
    int           pulses;

    vecs[0] = '{1'b1, K0, 1'b0, 128'h0, 2'd0, P0, 1'b1, C0};
    vecs[1] = '{1'b1, K1, 1'b0, 128'h0, 2'd0, P1, 1'b1, E1};
    vecs[2] = '{1'b1, K1, 1'b1, K0,     2'd1, P1, 1'b1, CBC1};
    vecs[3] = '{1'b0, K1, 1'b0, 128'h0, 2'd1, P2, 1'b1, CBC2};
    vecs[4] = '{1'b0, K1, 1'b1, CTRB,   2'd2, P1, 1'b1, CTR1};
    vecs[5] = '{1'b0, K1, 1'b0, 128'h0, 2'd2, P2, 1'b1, CTR2};
    vecs[6] = '{1'b1, K0, 1'b0, 128'h0, 2'd3, P0, 1'b1, C0};
    vecs[7] = '{1'b1, 128'h0, 1'b1, WRAP, 2'd2, 128'h0, 1'b0, 128'h0};
    vecs[8] = '{1'b0, 128'h0, 1'b0, 128'h0, 2'd2, 128'h0, 1'b1, ZENC};

    bus.Kin = 128'h0; bus.Krdy = 1'b0; bus.IVin = 128'h0; bus.IVrdy = 1'b0;
    bus.Mode = 2'd0; bus.Din = 128'h0; bus.Drdy = 1'b0;
    EN = 1'b1;
    RSTn = 1'b1;
    #1 RSTn = 1'b0;
    #1;
    chk("reset_dout", bus.Dout, 128'h0);
    chk("reset_dvld", 128'(bus.Dvld), 128'd0);
    chk("reset_kvld", 128'(bus.Kvld), 128'd0);
    chk("reset_bsy", 128'(bus.BSY), 128'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].load_key) load_key(vecs[i].key);
      if (vecs[i].load_iv) load_iv(vecs[i].iv);
      run_block(vecs[i].mode, vecs[i].din, 0, dout, lat);
      if (vecs[i].check) chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd11);
    end

    // Kvld is a single-cycle pulse.
    load_key(K1);
    @(negedge CLK);
    chk("kvld_pulse_end", 128'(bus.Kvld), 128'd0);

    // Krdy and Drdy together: key wins, block dropped.
    bus.Kin = K0; bus.Krdy = 1'b1; bus.Mode = 2'd0; bus.Din = P0; bus.Drdy = 1'b1;
    @(negedge CLK);
    bus.Krdy = 1'b0; bus.Drdy = 1'b0;
    chk("krdy_drdy_kvld", 128'(bus.Kvld), 128'd1);
    chk("krdy_drdy_bsy", 128'(bus.BSY), 128'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (bus.Dvld) pulses++;
    end
    chk("krdy_drdy_no_dvld", 128'(pulses), 128'd0);
    run_block(2'd0, P0, 0, dout, lat);
    chk("krdy_drdy_key_used", dout, C0);

    // Strobes while busy are ignored; exactly one Dvld pulse.
    bus.Mode = 2'd0; bus.Din = P0; bus.Drdy = 1'b1;
    @(negedge CLK);
    bus.Drdy = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.Din = P1; bus.Drdy = 1'b1; bus.Kin = K1; bus.Krdy = 1'b1;
    bus.IVin = CTRB; bus.IVrdy = 1'b1;
    @(negedge CLK);
    bus.Drdy = 1'b0; bus.Krdy = 1'b0; bus.IVrdy = 1'b0;
    chk("busy_krdy_no_kvld", 128'(bus.Kvld), 128'd0);
    pulses = 0;
    dout = 128'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus.Dvld) begin
        pulses++;
        dout = bus.Dout;
      end
    end
    chk("busy_single_dvld", 128'(pulses), 128'd1);
    chk("busy_dout", dout, C0);
    chk("dout_holds", bus.Dout, C0);
    run_block(2'd0, P0, 0, dout, lat);
    chk("key_not_overwritten", dout, C0);

    // EN low for three cycles mid-block delays Dvld by three.
    run_block(2'd0, P0, 5, dout, lat);
    chk("stall_latency", 128'(lat), 128'd14);
    chk("stall_dout", dout, C0);

    // Reset at round 5 aborts the block.
    bus.Mode = 2'd0; bus.Din = P1; bus.Drdy = 1'b1;
    @(negedge CLK);
    bus.Drdy = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge CLK);
    chk("midblock_bsy", 128'(bus.BSY), 128'd1);
    RSTn = 1'b0;
    #1;
    chk("midreset_dout", bus.Dout, 128'h0);
    chk("midreset_bsy", 128'(bus.BSY), 128'd0);
    chk("midreset_dvld", 128'(bus.Dvld), 128'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (bus.Dvld) pulses++;
    end
    chk("midreset_no_dvld", 128'(pulses), 128'd0);
    load_key(K0);
    run_block(2'd0, P0, 0, dout, lat);
    chk("post_reset_dout", dout, C0);
    chk("post_reset_latency", 128'(lat), 128'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_composite_modes.md
AES_COMPOSITE_MODES -- requirements
Module: aes_composite_modes

Interface
REQ-001 Parameter NR, default 10: number of AES rounds per block (10 for AES-128); legal range 2..14.
REQ-002 Parameter CTR_W, default 32: width of the CTR-mode counter field (low bits of the counter block); legal range 8..128.
REQ-003 Parameter MODES_EN, default 3'b111: enable mask, bit0 ECB, bit1 CBC, bit2 CTR; a disabled mode executes as ECB.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RSTn  input  1  reset, asynchronous assert, active-low.
REQ-006 EN  input  1  clock enable; when low, every register holds.
REQ-007 Kin  input  128  cipher key.
REQ-008 Krdy  input  1  key-load strobe.
REQ-009 IVin  input  128  IV (CBC) or initial counter block (CTR).
REQ-010 IVrdy  input  1  IV-load strobe.
REQ-011 Mode  input  2  mode: 0 ECB, 1 CBC, 2 CTR, 3 reserved (treated as ECB).
REQ-012 Din  input  128  plaintext block.
REQ-013 Drdy  input  1  block-start strobe.
REQ-014 Dout  output  128  result block.
REQ-015 Dvld  output  1  one-cycle pulse: Dout valid.
REQ-016 Kvld  output  1  one-cycle pulse: key accepted.
REQ-017 BSY  output  1  high while a block is in flight.

Function
REQ-018 FSM states: IDLE, RUN, DONE; all transitions qualified by EN.
REQ-019 In IDLE, priority Krdy > IVrdy > Drdy; lower-priority strobes in the same cycle are dropped.
REQ-020 Krdy in IDLE: key register loads Kin, Kvld pulses the next cycle; Krdy outside IDLE is ignored with no Kvld.
REQ-021 IVrdy in IDLE: chain register loads IVin; ignored outside IDLE.
REQ-022 Drdy accepted in IDLE only: latches Mode and Din, state register = cipher input XOR key, rcon = 8'h01, round counter = 1, BSY = 1, state -> RUN.
REQ-023 Cipher input: ECB Din; CBC Din XOR chain; CTR chain (counter block).
REQ-024 RUN: one round per cycle via the existing round core and key-expansion logic; final round (counter = NR) omits MixColumns; then -> DONE.
REQ-025 Latency: Drdy sampled at edge t -> Dvld = 1 and Dout valid after edge t+NR+1; Dvld high exactly one cycle; BSY drops on the same edge that raises Dvld.
REQ-026 Output: ECB and CBC Dout = cipher result; CTR Dout = latched Din XOR cipher result.
REQ-027 DONE -> IDLE unconditionally; Dout holds until the next block completes.
REQ-028 Chain update in DONE: CBC chain = ciphertext; CTR low CTR_W bits increment modulo 2^CTR_W with no carry into upper bits; ECB chain unchanged.
REQ-029 Drdy, Krdy or IVrdy during RUN or DONE is ignored, with no queuing.
REQ-030 Round key regenerates from the stored key for every block; the key register is never overwritten by round keys.
REQ-031 rcon steps by xtime per round (8'h80 -> 8'h1B).
REQ-032 With EN low mid-block, the block resumes after EN returns; latency is counted in enabled cycles.

Reset
REQ-033 RSTn low asynchronously forces: state IDLE; Dout 0; key 0; chain 0; rcon 8'h01; round counter 0; Dvld, Kvld and BSY 0.
REQ-034 Reset mid-block aborts it: no Dvld, chain not updated.

Structure
REQ-035 Package aes_comp_pkg holds the mode enum (ECB/CBC/CTR), the FSM state enum, RCON_INIT and the xtime function.
REQ-036 Reuse the existing AES round-core and key-expansion modules unchanged.
REQ-037 One new sub-module, aes_mode_unit, implements the cipher-input mux, the output XOR and the chain/counter register update.

Verification
REQ-038 ECB: Kin=000102..0f, Din=00112233445566778899aabbccddeeff -> Dout=69c4e0d86a7b0430d8cdb78070b4c55a, Dvld at t+11.
REQ-039 CBC (SP800-38A F.2.1): key 2b7e1516..., IV 000102..0f, block 1 -> 7649abac8119b246cee98e9b12e9197d; block 2 -> 5086cb9b507219ee95db113a917678b2.
REQ-040 CTR (F.5.1): counter block f0f1..feff, block 1 -> 874d6191b620e3261bef6864990db6ce; counter then ends in ...ff00 with CTR_W=32 (low-word wrap, no carry).
REQ-041 Krdy+Drdy in the same IDLE cycle -> only the key loads, Kvld pulses, no Dvld; Drdy during RUN -> ignored, a single Dvld.
REQ-042 RSTn low at round 5 -> all outputs 0 immediately, no Dvld; an ECB block afterwards (key reloaded) matches REQ-038.
REQ-043 EN low for 3 cycles mid-block -> Dvld delayed by exactly 3 cycles, Dout unchanged from REQ-038.
